// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and lane helpers for the MEM stage
package mem_access_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [31:0] DEAD_VAL = 32'hDEADBEEF;

  // Reserved size 2'b11 falls through to word handling in every helper.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// rtl/mem_access_stage_load_formatter.sv - lane select and sign/zero extension of load data
module load_formatter
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with wait-state data bus; DMEM_TIMEOUT_EN adds a bus timeout
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic        stall,
  output logic [31:0] data_out,
  output logic [4:0]  rd_out,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  logic [1:0]  state_q, state_d;
  logic        req_q, we_q, load_q, uns_q, err_q;
  logic [31:0] addr_q, wdata_q, result_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q, size_q;

  logic        mem_op, bad_align, start, ack_fire, timeout_hit;
  logic [31:0] fmt_data;

  assign mem_op    = valid_in & (mem_read | mem_write);
  assign bad_align = mem_op & is_misaligned(mem_size, alu_in[1:0]);
  assign start     = (state_q == ST_IDLE) & mem_op & ~bad_align;
  assign ack_fire  = (state_q == ST_WAIT) & dmem_ack;

  // Access attributes are latched so formatting does not depend on upstream holding.
  load_formatter u_fmt (
    .rdata_i    (dmem_rdata),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (fmt_data)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) tmo_cnt_q <= '0;
    else                           tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == ST_WAIT) & ~dmem_ack & (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err     = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES > 0;
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    data_out = alu_in;
    rd_out   = valid_in ? rd_in : 5'd0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          rd_out = 5'd0;
          if (bad_align) misalign = 1'b1;
          else           stall    = 1'b1;
        end
      end
      ST_WAIT: begin
        stall  = 1'b1;
        rd_out = 5'd0;
      end
      ST_DONE: begin
        data_out = result_q;
        rd_out   = (load_q && !err_q) ? rd_in : 5'd0;
      end
      default: rd_out = 5'd0;
    endcase
    if (rst) begin
      stall    = 1'b0;
      misalign = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      result_q <= '0;
      off_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= mem_write & ~mem_read;
        addr_q  <= {alu_in[31:2], 2'b00};
        wdata_q <= lane_wdata(mem_size, store_in);
        be_q    <= lane_be(mem_size, alu_in[1:0]);
        off_q   <= alu_in[1:0];
        size_q  <= mem_size;
        uns_q   <= mem_unsigned;
        load_q  <= mem_read;
      end
      if (ack_fire) begin
        req_q    <= 1'b0;
        we_q     <= 1'b0;
        result_q <= load_q ? fmt_data : 32'd0;
      end else if (timeout_hit) begin
        req_q    <= 1'b0;
        we_q     <= 1'b0;
        result_q <= DEAD_VAL;
        err_q    <= 1'b1;
      end
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_in, store_in;
  logic [4:0]  rd_in;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic        stall, misalign, bus_err;
  logic [31:0] data_out;
  logic [4:0]  rd_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_in(alu_in), .store_in(store_in),
    .rd_in(rd_in), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .stall(stall), .data_out(data_out), .rd_out(rd_out),
    .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; alu_in = 0; store_in = 0; rd_in = 0;
    mem_read = 0; mem_write = 0; mem_size = 2'b10; mem_unsigned = 0;
    dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                       input logic rd_en, input logic wr_en, input logic [1:0] size, input logic uns);
    valid_in = 1; alu_in = addr; store_in = sdata; rd_in = rd;
    mem_read = rd_en; mem_write = wr_en; mem_size = size; mem_unsigned = uns;
  endtask

  task automatic run_access(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] rd, input logic rd_en, input logic wr_en,
                            input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                            input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_data, input logic [4:0] exp_rd);
    drive(addr, sdata, rd, rd_en, wr_en, size, uns);
    #1;
    chk({tag, "/idle_stall"}, stall, 1);
    chk({tag, "/idle_req"}, dmem_req, 0);
    chk({tag, "/idle_rd"}, rd_out, 0);
    tick();
    chk({tag, "/req"}, dmem_req, 1);
    chk({tag, "/we"}, dmem_we, wr_en & ~rd_en);
    chk({tag, "/addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "/be"}, dmem_be, exp_be);
    if (wr_en && !rd_en) chk({tag, "/wdata"}, dmem_wdata, exp_wdata);
    chk({tag, "/wait_rd"}, rd_out, 0);
    chk({tag, "/wait_stall"}, stall, 1);
    for (int i = 1; i < waits; i++) begin
      tick();
      chk({tag, "/wait_stall_n"}, stall, 1);
      chk({tag, "/wait_req_n"}, dmem_req, 1);
    end
    dmem_ack = 1; dmem_rdata = rdata;
    tick();
    dmem_ack = 0; dmem_rdata = 32'h5555_5555;
    chk({tag, "/done_stall"}, stall, 0);
    chk({tag, "/done_req"}, dmem_req, 0);
    chk({tag, "/done_data"}, data_out, exp_data);
    chk({tag, "/done_rd"}, rd_out, exp_rd);
    chk({tag, "/done_buserr"}, bus_err, 0);
    tick();
    idle_inputs();
    #1;
    chk({tag, "/after_stall"}, stall, 0);
    chk({tag, "/after_req"}, dmem_req, 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst/stall", stall, 0);
    chk("rst/misalign", misalign, 0);
    chk("rst/bus_err", bus_err, 0);
    chk("rst/req", dmem_req, 0);
    chk("rst/we", dmem_we, 0);
    chk("rst/addr", dmem_addr, 0);
    chk("rst/wdata", dmem_wdata, 0);
    chk("rst/be", dmem_be, 0);

    // plain ALU passthrough
    valid_in = 1; alu_in = 32'h1234; rd_in = 5;
    #1;
    chk("alu/data", data_out, 32'h1234);
    chk("alu/rd", rd_out, 5);
    chk("alu/stall", stall, 0);
    valid_in = 0;
    #1;
    chk("bubble/rd", rd_out, 0);
    tick();
    idle_inputs();

    //          tag      addr          store         rd  rd wr size   u rdata         w  be       wdata         data          rd
    run_access("lb",    32'h103,      32'h0,        7,  1, 0, 2'b00, 0, 32'h80FF0000, 2, 4'b1000, 32'h0,        32'hFFFFFF80, 7);
    run_access("lbu",   32'h103,      32'h0,        8,  1, 0, 2'b00, 1, 32'h80FF0000, 1, 4'b1000, 32'h0,        32'h00000080, 8);
    run_access("lh",    32'h102,      32'h0,        9,  1, 0, 2'b01, 0, 32'h80010000, 1, 4'b1100, 32'h0,        32'hFFFF8001, 9);
    run_access("lhu",   32'h102,      32'h0,        9,  1, 0, 2'b01, 1, 32'h80010000, 1, 4'b1100, 32'h0,        32'h00008001, 9);
    run_access("lw",    32'h300,      32'h0,        10, 1, 0, 2'b10, 0, 32'h12345678, 1, 4'b1111, 32'h0,        32'h12345678, 10);
    run_access("lb_x0", 32'h100,      32'h0,        0,  1, 0, 2'b00, 0, 32'h0000007F, 1, 4'b0001, 32'h0,        32'h0000007F, 0);
    run_access("sh",    32'h202,      32'h0000ABCD, 0,  0, 1, 2'b01, 0, 32'h0,        3, 4'b1100, 32'hABCDABCD, 32'h0,        0);
    run_access("sb",    32'h201,      32'h1234565A, 4,  0, 1, 2'b00, 0, 32'h0,        1, 4'b0010, 32'h5A5A5A5A, 32'h0,        0);
    run_access("sw",    32'h304,      32'hCAFEF00D, 0,  0, 1, 2'b10, 0, 32'h0,        2, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    run_access("rdwr",  32'h308,      32'hFFFFFFFF, 11, 1, 1, 2'b10, 0, 32'h0BADF00D, 1, 4'b1111, 32'h0,        32'h0BADF00D, 11);
    run_access("rsvsz", 32'h30C,      32'h0,        12, 1, 0, 2'b11, 0, 32'h87654321, 1, 4'b1111, 32'h0,        32'h87654321, 12);

    // misaligned accesses are dropped with a pulse
    drive(32'h101, 32'h0, 6, 1, 0, 2'b10, 0);
    #1;
    chk("mis_lw/misalign", misalign, 1);
    chk("mis_lw/stall", stall, 0);
    chk("mis_lw/rd", rd_out, 0);
    tick();
    chk("mis_lw/req", dmem_req, 0);
    drive(32'h201, 32'h55, 0, 0, 1, 2'b01, 0);
    #1;
    chk("mis_sh/misalign", misalign, 1);
    tick();
    chk("mis_sh/req", dmem_req, 0);
    idle_inputs();
    #1;
    chk("mis_clear", misalign, 0);

    // reset while waiting on the bus
    drive(32'h400, 32'h0, 3, 1, 0, 2'b10, 0);
    tick();
    chk("rstwait/req", dmem_req, 1);
    rst = 1;
    tick();
    chk("rstwait/req_drop", dmem_req, 0);
    chk("rstwait/stall", stall, 0);
    dmem_ack = 1; dmem_rdata = 32'h11111111;
    tick();
    rst = 0;
    idle_inputs();
    alu_in = 32'h77; valid_in = 1; rd_in = 2;
    dmem_ack = 1; dmem_rdata = 32'h22222222;
    #1;
    chk("rstwait/idle_data", data_out, 32'h77);
    chk("rstwait/idle_rd", rd_out, 2);
    tick();
    dmem_ack = 0;
    chk("rstwait/late_ack_req", dmem_req, 0);
    chk("rstwait/late_ack_stall", stall, 0);
    chk("rstwait/late_ack_data", data_out, 32'h77);
    idle_inputs();

`ifdef DMEM_TIMEOUT_EN
    drive(32'h500, 32'h0, 3, 1, 0, 2'b10, 0);
    tick();
    chk("tmo/req", dmem_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo/wait_req", dmem_req, 1);
      chk("tmo/wait_err", bus_err, 0);
    end
    tick();
    chk("tmo/bus_err", bus_err, 1);
    chk("tmo/req_drop", dmem_req, 0);
    chk("tmo/data", data_out, 32'hDEADBEEF);
    chk("tmo/rd", rd_out, 0);
    chk("tmo/stall", stall, 0);
    tick();
    idle_inputs();
    #1;
    chk("tmo/err_clear", bus_err, 0);
`else
    drive(32'h500, 32'h0, 3, 1, 0, 2'b10, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("notmo/req_held", dmem_req, 1);
      chk("notmo/bus_err", bus_err, 0);
    end
    dmem_ack = 1; dmem_rdata = 32'h0000ABCD;
    tick();
    dmem_ack = 0;
    chk("notmo/data", data_out, 32'h0000ABCD);
    chk("notmo/rd", rd_out, 3);
    tick();
    idle_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
